// File: rtl/encode_packet_ext.sv
// USB transmit packet encoder: handshake, token, SOF and data packets onto an AXI-Stream byte bus.
// Build option USB_TX_SOF_EN adds an internal frame counter that emits SOF tokens on sof_tick_i.
module encode_packet_ext #(
  parameter int MAX_LENGTH = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        tx_tlast_o,
  output logic [7:0]  tx_tdata_o,
  input  logic        hsk_send_i,
  output logic        hsk_done_o,
  input  logic [1:0]  hsk_type_i,
  input  logic        tok_send_i,
  output logic        tok_done_o,
  input  logic [1:0]  tok_type_i,
  input  logic [15:0] tok_data_i,
  input  logic        sof_tick_i,
  input  logic        trn_start_i,
  input  logic [1:0]  trn_type_i,
  input  logic        trn_tvalid_i,
  output logic        trn_tready_o,
  input  logic        trn_tlast_i,
  input  logic [7:0]  trn_tdata_i,
  output logic        err_len_o,
  output logic        err_urun_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);
  localparam int CW = $clog2(MAX_LENGTH + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LENGTH);

  typedef enum logic [2:0] {IDLE, PID, TOK0, TOK1, DATA, CRC0, CRC1, DONE} state_t;
  typedef enum logic [1:0] {K_HSK, K_TOK, K_SOF, K_DAT} kind_t;

  state_t        state;
  kind_t         kind;
  logic [3:0]    pid;
  logic [15:0]   crc;
  logic          bad;
  logic          drain;
  logic          data_pend;
  logic [CW-1:0] count;
  logic [15:0]   tok_word;
  logic          slot_free;
  logic          idle_open;
  logic          sof_pend;
  logic          sof_take;
  logic [15:0]   sof_word;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Handshake contract, both byte streams: a byte moves on a clock edge where valid and
  // ready are both high; once valid is raised, data/last hold until that edge.
  assign slot_free    = !tx_tvalid_o || tx_tready_i;
  assign trn_tready_o = drain || ((state == DATA) && slot_free);
  assign idle_open    = (state == IDLE) && !hsk_done_o && !tok_done_o;
  assign sof_take     = idle_open && !hsk_send_i && sof_pend;
  assign state_o      = state;

`ifdef USB_TX_SOF_EN
  logic [10:0] frame;

  function automatic logic [4:0] crc5_frame(input logic [10:0] d);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return ~r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      frame    <= '0;
      sof_pend <= 1'b0;
    end else if (sof_tick_i) begin
      frame    <= frame + 11'd1;
      sof_pend <= 1'b1;
    end else if (sof_take) begin
      sof_pend <= 1'b0;
    end
  end

  assign sof_word = {crc5_frame(frame), frame};
`else
  logic sof_unused;
  assign sof_unused = sof_tick_i;
  assign sof_pend   = 1'b0;
  assign sof_word   = 16'h0000;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      kind        <= K_HSK;
      pid         <= '0;
      crc         <= 16'hFFFF;
      bad         <= 1'b0;
      drain       <= 1'b0;
      data_pend   <= 1'b0;
      count       <= '0;
      tok_word    <= '0;
      tx_tvalid_o <= 1'b0;
      tx_tlast_o  <= 1'b0;
      tx_tdata_o  <= '0;
      hsk_done_o  <= 1'b0;
      tok_done_o  <= 1'b0;
      err_len_o   <= 1'b0;
      err_urun_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      hsk_done_o <= 1'b0;
      tok_done_o <= 1'b0;
      err_len_o  <= 1'b0;
      err_urun_o <= 1'b0;
      if (tx_tvalid_o && tx_tready_i) begin
        tx_tvalid_o <= 1'b0;
        tx_tlast_o  <= 1'b0;
      end
      // trn_start_i is a strobe; it is remembered until the data packet wins arbitration.
      if (trn_start_i) data_pend <= 1'b1;
      if (drain && trn_tvalid_i && trn_tlast_i) drain <= 1'b0;

      case (state)
        IDLE: if (idle_open) begin
          if (hsk_send_i) begin
            kind <= K_HSK; pid <= {hsk_type_i, 2'b10}; state <= PID; busy_o <= 1'b1;
          end else if (sof_pend) begin
            kind <= K_SOF; pid <= 4'b0101; tok_word <= sof_word; state <= PID; busy_o <= 1'b1;
          end else if (tok_send_i) begin
            kind <= K_TOK; pid <= {tok_type_i, 2'b01}; tok_word <= tok_data_i;
            state <= PID; busy_o <= 1'b1;
          end else if ((data_pend || trn_start_i) && !drain) begin
            kind <= K_DAT; pid <= {trn_type_i, 2'b11}; data_pend <= 1'b0;
            state <= PID; busy_o <= 1'b1;
          end
        end
        PID: if (slot_free) begin
          tx_tdata_o  <= {~pid, pid};
          tx_tvalid_o <= 1'b1;
          tx_tlast_o  <= (kind == K_HSK);
          crc         <= 16'hFFFF;
          bad         <= 1'b0;
          count       <= '0;
          case (kind)
            K_HSK:   state <= DONE;
            K_DAT:   state <= trn_tvalid_i ? DATA : CRC0;
            default: state <= TOK0;
          endcase
        end
        TOK0: if (slot_free) begin
          tx_tdata_o <= tok_word[7:0]; tx_tvalid_o <= 1'b1; tx_tlast_o <= 1'b0; state <= TOK1;
        end
        TOK1: if (slot_free) begin
          tx_tdata_o <= tok_word[15:8]; tx_tvalid_o <= 1'b1; tx_tlast_o <= 1'b1; state <= DONE;
        end
        DATA: begin
          if (trn_tvalid_i && trn_tready_o) begin
            if (count == MAX_CNT) begin
              // Over-length byte is swallowed; the rest of the packet is drained upstream.
              bad       <= 1'b1;
              err_len_o <= 1'b1;
              drain     <= !trn_tlast_i;
              state     <= CRC0;
            end else begin
              tx_tdata_o  <= trn_tdata_i;
              tx_tvalid_o <= 1'b1;
              tx_tlast_o  <= 1'b0;
              crc         <= crc16_upd(crc, trn_tdata_i);
              count       <= count + CW'(1);
              if (trn_tlast_i) state <= CRC0;
            end
          end else if (!trn_tvalid_i && (count != '0)) begin
            bad        <= 1'b1;
            err_urun_o <= 1'b1;
            state      <= CRC0;
          end
        end
        CRC0: if (slot_free) begin
          tx_tdata_o  <= bad ? crc[7:0] : ~crc[7:0];
          tx_tvalid_o <= 1'b1;
          tx_tlast_o  <= 1'b0;
          state       <= CRC1;
        end
        CRC1: if (slot_free) begin
          tx_tdata_o  <= bad ? crc[15:8] : ~crc[15:8];
          tx_tvalid_o <= 1'b1;
          tx_tlast_o  <= 1'b1;
          state       <= DONE;
        end
        DONE: if (slot_free) begin
          hsk_done_o <= (kind == K_HSK);
          tok_done_o <= (kind == K_TOK);
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
